// File: rtl/bcd_counter_4dig.sv
// bcd_counter_4dig -- four-digit BCD up/down counter with prescaler.
//
// A prescaler divides clk by PRESCALE; each completed prescale period
// (while count_en=1) steps the BCD count up or down by one in decimal,
// wrapping 9999<->0000. A synchronous load writes load_val, forcing any
// invalid (>9) nibble to 0 and flagging it on load_err.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero
// digits on digit_on; otherwise digit_on is constant 4'b1111.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   count_en  in   run enable; prescaler advances only while 1
//   up_dn     in   direction, 1=up, 0=down, sampled at each step
//   load      in   synchronous load strobe (priority over a step)
//   load_val  in   16  four BCD digits, [15:12]=thousands
//   bcd_out   out  16  registered count
//   digit_on  out  4   per-digit display enable
//   tick      out  one-cycle pulse when bcd_out shows a stepped value
//   rollover  out  one-cycle pulse with tick when the step wrapped
//   load_err  out  one-cycle pulse after a load containing a nibble >9
module bcd_counter_4dig #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_on,
  output logic        tick,
  output logic        rollover,
  output logic        load_err
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;
  logic          lerr_q, lerr_d;

  logic          step;
  logic [15:0]   step_val;
  logic          step_wrap;
  logic [15:0]   load_fix;
  logic          load_bad;

  assign step = count_en && (presc_q == PRESC_LAST);

  // Ripple a decimal carry/borrow from the units digit upward; a carry
  // surviving past the thousands digit means the count wrapped.
  always_comb begin
    logic       carry;
    logic [3:0] nib;
    carry    = 1'b1;
    nib      = '0;
    step_val = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      nib = bcd_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (nib >= 4'd9) begin
            nib = '0;
          end else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            nib = 4'd9;
          end else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = nib;
    end
    step_wrap = carry;
  end

  always_comb begin
    load_fix = load_val;
    load_bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_fix[4*i +: 4] = '0;
        load_bad           = 1'b1;
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    lerr_d  = 1'b0;
    if (load) begin
      bcd_d   = load_fix;
      presc_d = '0;
      lerr_d  = load_bad;
    end else if (count_en) begin
      if (step) begin
        presc_d = '0;
        bcd_d   = step_val;
        tick_d  = 1'b1;
        roll_d  = step_wrap;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign tick     = tick_q;
  assign rollover = roll_q;
  assign load_err = lerr_q;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it or any more-significant digit is nonzero.
  assign digit_on[0] = 1'b1;
  assign digit_on[1] = |bcd_q[15:4];
  assign digit_on[2] = |bcd_q[15:8];
  assign digit_on[3] = |bcd_q[15:12];
`else
  assign digit_on = '1;
`endif

endmodule

// File: tb/tb_bcd_counter_4dig.sv
module tb_bcd_counter_4dig;

  logic        clk = 1'b0;
  logic        rst, en, ud, ld;
  logic [15:0] lv;

  logic [15:0] bcd4, bcd1;
  logic [3:0]  don4, don1;
  logic        tick4, tick1, roll4, roll1, lerr4, lerr1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_counter_4dig #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(rst), .count_en(en), .up_dn(ud), .load(ld),
    .load_val(lv), .bcd_out(bcd4), .digit_on(don4), .tick(tick4),
    .rollover(roll4), .load_err(lerr4)
  );

  bcd_counter_4dig #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(rst), .count_en(en), .up_dn(ud), .load(ld),
    .load_val(lv), .bcd_out(bcd1), .digit_on(don1), .tick(tick1),
    .rollover(roll1), .load_err(lerr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  typedef struct packed {
    int val;
    int presc;
    bit tick;
    bit roll;
    bit lerr;
  } mstate_t;

  typedef struct packed {
    logic [15:0] bcd;
    logic        tick;
    logic        roll;
    logic        lerr;
    logic [3:0]  don;
  } exp_t;

  function automatic logic [15:0] tobcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] dexp(input int v);
`ifdef LEADING_ZERO_BLANK_EN
    if (v >= 1000) return 4'b1111;
    if (v >= 100)  return 4'b0111;
    if (v >= 10)   return 4'b0011;
    return 4'b0001;
`else
    return 4'b1111;
`endif
  endfunction

  function automatic mstate_t mstep(input mstate_t m, input int ps);
    mstate_t n;
    n      = m;
    n.tick = 1'b0;
    n.roll = 1'b0;
    n.lerr = 1'b0;
    if (rst) begin
      n.val   = 0;
      n.presc = 0;
    end else if (ld) begin
      int v;
      v = 0;
      for (int k = 3; k >= 0; k--) begin
        int nb;
        nb = int'(lv[4*k +: 4]);
        if (nb > 9) begin
          nb     = 0;
          n.lerr = 1'b1;
        end
        v = v * 10 + nb;
      end
      n.val   = v;
      n.presc = 0;
    end else if (en) begin
      if (m.presc == ps - 1) begin
        n.presc = 0;
        n.tick  = 1'b1;
        if (ud) begin
          n.val  = (m.val + 1) % 10000;
          n.roll = (m.val == 9999);
        end else begin
          n.val  = (m.val == 0) ? 9999 : m.val - 1;
          n.roll = (m.val == 0);
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mkexp(input mstate_t m);
    exp_t e;
    e.bcd  = tobcd(m.val);
    e.tick = m.tick;
    e.roll = m.roll;
    e.lerr = m.lerr;
    e.don  = dexp(m.val);
    return e;
  endfunction

  mstate_t m4 = '0, m1 = '0;
  bit      armed = 1'b0;
  exp_t    q4[$], q1[$];
  exp_t    e4, e1;

  // Stimulus applied at this edge: advance the model and queue the outcome.
  always @(posedge clk) begin
    if (rst) armed = 1'b1;
    m4 = mstep(m4, 4);
    m1 = mstep(m1, 1);
    if (armed) begin
      q4.push_back(mkexp(m4));
      q1.push_back(mkexp(m1));
    end
  end

  always @(negedge clk) begin
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("sb4.bcd",  bcd4,  e4.bcd);
      check("sb4.tick", tick4, e4.tick);
      check("sb4.roll", roll4, e4.roll);
      check("sb4.lerr", lerr4, e4.lerr);
      check("sb4.don",  don4,  e4.don);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("sb1.bcd",  bcd1,  e1.bcd);
      check("sb1.tick", tick1, e1.tick);
      check("sb1.roll", roll1, e1.roll);
      check("sb1.lerr", lerr1, e1.lerr);
      check("sb1.don",  don1,  e1.don);
    end
  end

  // ---------------- directed sequence ----------------
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] DON_RST  = 4'b0001;
  localparam logic [3:0] DON_0099 = 4'b0011;
`else
  localparam logic [3:0] DON_RST  = 4'b1111;
  localparam logic [3:0] DON_0099 = 4'b1111;
`endif

  // PRESCALE=4 instance: three quiet cycles, then a step showing exp_val.
  task automatic wait_step4(input string tag, input logic [15:0] exp_val);
    repeat (3) begin
      @(negedge clk);
      check({tag, ".quiet"}, tick4, 1'b0);
    end
    @(negedge clk);
    check({tag, ".tick"}, tick4, 1'b1);
    check({tag, ".bcd"}, bcd4, exp_val);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ud = 1'b1; ld = 1'b0; lv = '0;
    @(negedge clk);
    check("rst.bcd",  bcd4,  16'h0000);
    check("rst.tick", tick4, 1'b0);
    check("rst.roll", roll4, 1'b0);
    check("rst.lerr", lerr4, 1'b0);
    check("rst.don",  don4,  DON_RST);

    // Free-running up count
    rst = 1'b0; en = 1'b1; ud = 1'b1;
    wait_step4("up1", 16'h0001);
    check("up1.roll", roll4, 1'b0);
    wait_step4("up2", 16'h0002);

    // Wrap 9999 -> 0000
    ld = 1'b1; lv = 16'h9998;
    @(negedge clk);
    ld = 1'b0;
    check("ld9998.bcd", bcd4, 16'h9998);
    wait_step4("w9999", 16'h9999);
    check("w9999.roll", roll4, 1'b0);
    wait_step4("w0000", 16'h0000);
    check("w0000.roll", roll4, 1'b1);
    wait_step4("w0001", 16'h0001);
    check("w0001.roll", roll4, 1'b0);

    // Invalid-nibble load, then load coincident with a step
    ld = 1'b1; lv = 16'h1A3F;
    @(negedge clk);
    ld = 1'b0;
    check("bad.bcd",  bcd4,  16'h1030);
    check("bad.lerr", lerr4, 1'b1);
    @(negedge clk);
    check("bad.lerr_off", lerr4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    ld = 1'b1; lv = 16'h1234;
    @(negedge clk);
    ld = 1'b0;
    check("ldstep.bcd",  bcd4,  16'h1234);
    check("ldstep.tick", tick4, 1'b0);

    // Enable dropped mid-period
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("hold.tick", tick4, 1'b0);
      check("hold.bcd",  bcd4,  16'h1234);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume.quiet", tick4, 1'b0);
    @(negedge clk);
    check("resume.tick", tick4, 1'b1);
    check("resume.bcd",  bcd4,  16'h1235);

    // Direction change mid-period takes effect at the next step
    @(negedge clk);
    ud = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("dir.quiet", tick4, 1'b0);
    end
    @(negedge clk);
    check("dir.tick", tick4, 1'b1);
    check("dir.bcd",  bcd4,  16'h1234);

    // Reset coincident with a step
    ud = 1'b1; ld = 1'b1; lv = 16'h0437;
    @(negedge clk);
    ld = 1'b0;
    check("ld0437.bcd", bcd4, 16'h0437);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rststep.bcd",  bcd4,  16'h0000);
    check("rststep.tick", tick4, 1'b0);
    wait_step4("rstfirst", 16'h0001);

    // PRESCALE=1 instance: every enabled cycle steps
    ld = 1'b1; lv = 16'h0100; ud = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    check("p1.ld", bcd1, 16'h0100);
    @(negedge clk);
    check("p1.0099",   bcd1,  16'h0099);
    check("p1.tick",   tick1, 1'b1);
    check("p1.don",    don1,  DON_0099);
    @(negedge clk);
    check("p1.0098",   bcd1,  16'h0098);
    ld = 1'b1; lv = 16'h0000;
    @(negedge clk);
    ld = 1'b0;
    check("p1.ld0", bcd1, 16'h0000);
    @(negedge clk);
    check("p1.dnwrap", bcd1,  16'h9999);
    check("p1.dnroll", roll1, 1'b1);
    ud = 1'b1;
    @(negedge clk);
    check("p1.upwrap", bcd1,  16'h0000);
    check("p1.uproll", roll1, 1'b1);

    // Random traffic, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 4))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9998;
        3: lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_4dig.md
BCD_COUNTER_4DIG -- requirements
Module: bcd_counter_4dig

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 50_000_000, meaning clock cycles per count step when enabled; legal range 1 to 2^26.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-003 count_en  in  1  run enable; prescaler advances only while 1.
REQ-004 up_dn  in  1  count direction, 1=up, 0=down; sampled at each step.
REQ-005 load  in  1  synchronous load strobe.
REQ-006 load_val  in  16  four BCD digits, [15:12]=thousands, [3:0]=units.
REQ-007 bcd_out  out  16  registered count, 4 BCD digits; feeds four seven-segment decoder instances, one nibble each.
REQ-008 digit_on  out  4  per-digit display enable; bit i drives display_on of the decoder for nibble i.
REQ-009 tick  out  1  one-cycle pulse, high in the cycle bcd_out first shows a stepped value.
REQ-010 rollover  out  1  one-cycle pulse coincident with tick when the step wrapped.
REQ-011 load_err  out  1  one-cycle pulse, high the cycle after a load containing a nibble >9.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1, advancing only when count_en=1 and holding its value when count_en=0.
REQ-013 When the prescaler is at PRESCALE-1 and count_en=1, a step SHALL occur at that edge and the prescaler SHALL wrap to 0; with PRESCALE=1 every enabled cycle is a step.
REQ-014 An up step SHALL increment bcd_out in decimal, with digit carry on 9->0; 9999 SHALL wrap to 0000 with rollover=1.
REQ-015 A down step SHALL decrement bcd_out in decimal, with digit borrow on 0->9; 0000 SHALL wrap to 9999 with rollover=1.
REQ-016 Latency SHALL be one edge: bcd_out, tick and rollover all update at the same edge that completes the prescale period.
REQ-017 tick and rollover SHALL be 0 in every cycle without a step.
REQ-018 load=1 SHALL have priority over a coincident step: bcd_out<=load_val and prescaler<=0 at that edge, with tick=0 and rollover=0 in the following cycle.
REQ-019 On load, any nibble of load_val greater than 9 SHALL load as 0, the other nibbles SHALL load unchanged, and load_err SHALL pulse.
REQ-020 bcd_out SHALL never hold a nibble greater than 9.
REQ-021 digit_on SHALL be combinational from the registered bcd_out only (no extra latency), per REQ-027/028.
REQ-022 A change of up_dn between steps SHALL take effect at the next step, with no glitch step and no prescaler reset.

Reset
REQ-023 Reset SHALL be synchronous and active-high and SHALL override load and count_en.
REQ-024 On reset, bcd_out=16'h0000, prescaler=0, tick=0, rollover=0 and load_err=0, all in the cycle after the reset edge.
REQ-025 Reset asserted in the same cycle as a step SHALL suppress the step; the count SHALL restart from 0000 with a full PRESCALE period after reset deasserts.
REQ-026 After reset, digit_on SHALL be 4'b0001 with the macro defined and 4'b1111 without it.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, leading-zero blanking SHALL apply:
- digit_on[0]=1 always.
- digit_on[i] for i=1..3 = 1 if any nibble at position >=i is nonzero, else 0.
REQ-028 With LEADING_ZERO_BLANK_EN undefined, digit_on SHALL be constant 4'b1111 and no blanking logic SHALL be synthesised.

Verification
REQ-029 PRESCALE=4, reset, count_en=1, up_dn=1 -> bcd_out 0001 after 4 cycles, tick high 1 cycle every 4 cycles, rollover=0.
REQ-030 PRESCALE=4, load 16'h9998, up -> 9999 then 0000; rollover=1 with tick at the 0000 step; then 0001.
REQ-031 PRESCALE=1, load 16'h0100, up_dn=0 -> 0099, 0098 on successive cycles; digit_on 0011 with the macro defined, 1111 without.
REQ-032 Load 16'h1A3F -> bcd_out=1030, load_err pulses 1 cycle; load coincident with a step -> load value wins, tick=0.
REQ-033 count_en dropped mid-period for 10 cycles -> prescaler holds, and the step occurs after the remaining cycles once re-enabled.
REQ-034 Reset asserted at 0437 coincident with a step -> bcd_out=0000, tick=0, and the first step occurs exactly PRESCALE enabled cycles after reset deasserts.
